uart_host_write_fifo: RTL and testbench
=======================================

Name: uart_host_write_fifo

Overview:
Parametrised host-side write interface for the UART: the next generation of the single-byte write latch. Host write strobes (baud-rate low/high, TX data) are edge-detected and commit on strobe deassertion. Baud divisor widens to BRG_W bits with atomic low/high update, and TX data goes into a DEPTH-entry FIFO with valid/ready drain toward the transmitter, plus full/empty/count and sticky overflow status.

Parameters:
DATA_W, 8, host data bus width and FIFO word width
BRG_W, 16, baud divisor width; must satisfy DATA_W < BRG_W <= 2*DATA_W
DEPTH, 16, FIFO entries; power of two, >= 2
EDGE_POL, 0, 0 = commit on falling edge of strobe, 1 = commit on rising edge

Ports:
i_Clock  in  1  single clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
brg_lo_we  in  1  host strobe: stage low DATA_W bits of divisor
brg_hi_we  in  1  host strobe: commit upper BRG_W-DATA_W bits plus staged low bits
data_we  in  1  host strobe: push i_data into TX FIFO
ovf_clr  in  1  level; clears sticky overflow
i_data  in  DATA_W  host write data
brg_reg  out  BRG_W  active baud divisor
brg_update  out  1  one-cycle pulse, cycle after brg_reg changes
out_data  out  DATA_W  FIFO head word (valid when out_valid)
out_valid  out  1  FIFO not empty
out_ready  in  1  transmitter accepts head word
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (i_reset high at a clock edge): strobe history regs, brg_lo_stage, brg_reg, pointers, count, overflow, brg_update all 0. out_valid = 0, full = 0. Reset wins over every simultaneous event; a transfer in progress is lost.
- Edge detect: each strobe registered once (x_q). EDGE_POL=0: commit = x_q & ~x; EDGE_POL=1: commit = ~x_q & x. Commit is combinational and acts at the same clock edge; i_data is sampled at that edge. One commit per strobe pulse regardless of pulse length.
- After reset x_q = 0. With EDGE_POL=0, a strobe held high through reset commits on its first post-reset fall (intended).
- brg_lo_we commit: brg_lo_stage <= i_data; brg_reg unchanged.
- brg_hi_we commit: brg_reg <= {i_data[BRG_W-DATA_W-1:0], brg_lo_stage}; brg_update = 1 the following cycle only. Upper i_data bits ignored.
- Simultaneous lo and hi commit at the same edge: brg_reg takes the hi bits and the NEW low bits (i_data); brg_lo_stage also updates.
- Hi commit with no prior lo commit since reset uses stage value 0.
- FIFO: push = data_we commit; pop = out_valid & out_ready. out_data = mem[rd_ptr], combinational show-ahead. Push data is visible on out_data the cycle after the push edge when the FIFO was empty (push-to-valid latency 1).
- Pointers are $clog2(DEPTH) bits and wrap naturally. count +1 on push only, -1 on pop only, unchanged on both.
- Push while full and no pop: word dropped, state unchanged, overflow <= 1.
- Push while full with pop in the same cycle: accepted; count stays DEPTH.
- Pop while empty: impossible (out_valid = 0); out_ready ignored.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.

Test Plan:
- Reset, then data_we pulse high 3 cycles with i_data=0xA5 -> exactly one push at fall; next cycle out_valid=1, out_data=0xA5, count=1.
- brg_lo_we with 0x34, then brg_hi_we with 0x12 -> brg_reg stays 0x0000 after lo; becomes 0x1234 at hi fall; brg_update high exactly one cycle.
- Push 16 words 0x00..0x0F with out_ready=0 -> full=1, count=16. 17th push 0xFF -> dropped, overflow=1. Drain -> 0x00..0x0F in order, then out_valid=0.
- With FIFO full, push 0x55 in the same cycle as a pop -> count stays 16, 0x55 emerges last. ovf_clr with no push -> overflow=0.
- Write/read 40 words with a random out_ready pattern -> order preserved across pointer wrap; count never exceeds 16.
- Assert i_reset mid-stream with count=5 and data_we high -> next cycle count=0, out_valid=0, brg_reg=0, overflow=0. EDGE_POL=1 build: commit on rising edge.

Source files
------------

// File: rtl/uart_host_write_fifo.sv
// Host write port for the UART: edge-committed baud divisor registers plus a TX data FIFO.
// Latency: a strobe commits at the clock edge where its selected edge is seen; a pushed word reaches out_data one cycle later.
// Backpressure: out_valid/out_ready drain; a push into a full FIFO with no pop is dropped and sets sticky overflow.
//
// Ports:
//   i_Clock, i_reset          : single clock, synchronous active-high reset
//   brg_lo_we, brg_hi_we      : host strobes staging / committing the baud divisor
//   data_we, i_data           : host strobe and data pushing into the TX FIFO
//   ovf_clr                   : level clear of the sticky overflow flag
//   brg_reg, brg_update       : active divisor and one-cycle "divisor changed" pulse
//   out_data/out_valid/out_ready : show-ahead FIFO drain toward the transmitter
//   full, count, overflow     : FIFO status
module uart_host_write_fifo #(
  parameter int DATA_W   = 8,
  parameter int BRG_W    = 16,
  parameter int DEPTH    = 16,
  parameter int EDGE_POL = 0
) (
  input  logic                     i_Clock,
  input  logic                     i_reset,
  input  logic                     brg_lo_we,
  input  logic                     brg_hi_we,
  input  logic                     data_we,
  input  logic                     ovf_clr,
  input  logic [DATA_W-1:0]        i_data,
  output logic [BRG_W-1:0]         brg_reg,
  output logic                     brg_update,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int HI_W = BRG_W - DATA_W;

  // strobe history for edge detection
  logic brg_lo_q;
  logic brg_hi_q;
  logic data_q;

  logic lo_cmt;
  logic hi_cmt;
  logic push;

  generate
    if (EDGE_POL != 0) begin : g_rise
      assign lo_cmt = ~brg_lo_q & brg_lo_we;
      assign hi_cmt = ~brg_hi_q & brg_hi_we;
      assign push   = ~data_q   & data_we;
    end else begin : g_fall
      assign lo_cmt = brg_lo_q & ~brg_lo_we;
      assign hi_cmt = brg_hi_q & ~brg_hi_we;
      assign push   = data_q   & ~data_we;
    end
  endgenerate

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      brg_lo_q <= 1'b0;
      brg_hi_q <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      brg_lo_q <= brg_lo_we;
      brg_hi_q <= brg_hi_we;
      data_q   <= data_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud divisor
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] brg_lo_stage;
  logic [DATA_W-1:0] lo_next;

  // A low write landing on the same edge as the high write must be seen by it.
  assign lo_next = lo_cmt ? i_data : brg_lo_stage;

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      brg_lo_stage <= '0;
      brg_reg      <= '0;
      brg_update   <= 1'b0;
    end else begin
      brg_lo_stage <= lo_next;
      brg_update   <= hi_cmt;
      if (hi_cmt) begin
        brg_reg <= {i_data[HI_W-1:0], lo_next};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop;
  logic              push_ok;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok   = push & (~full | pop);

  always_ff @(posedge i_Clock) begin
    if (!i_reset && push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a dropped push outranks a simultaneous clear
      if (push & ~push_ok) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_host_write_fifo.sv
module tb_uart_host_write_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        brg_lo_we, brg_hi_we, data_we, ovf_clr, out_ready;
  logic [7:0]  i_data;
  logic [15:0] brg_reg;
  logic        brg_update, out_valid, full, overflow;
  logic [7:0]  out_data;
  logic [4:0]  count;

  // rising-edge build, only its data strobe and drain are exercised
  logic        r_we, r_rdy, r_zero;
  logic [15:0] r_brg;
  logic        r_upd, r_valid, r_full, r_ovf;
  logic [7:0]  r_out;
  logic [4:0]  r_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_host_write_fifo #(.DATA_W(8), .BRG_W(16), .DEPTH(16), .EDGE_POL(0)) dut (
    .i_Clock(clk), .i_reset(rst), .brg_lo_we(brg_lo_we), .brg_hi_we(brg_hi_we),
    .data_we(data_we), .ovf_clr(ovf_clr), .i_data(i_data), .brg_reg(brg_reg),
    .brg_update(brg_update), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .full(full), .count(count), .overflow(overflow)
  );

  uart_host_write_fifo #(.DATA_W(8), .BRG_W(16), .DEPTH(16), .EDGE_POL(1)) dut_rise (
    .i_Clock(clk), .i_reset(rst), .brg_lo_we(r_zero), .brg_hi_we(r_zero),
    .data_we(r_we), .ovf_clr(r_zero), .i_data(i_data), .brg_reg(r_brg),
    .brg_update(r_upd), .out_data(r_out), .out_valid(r_valid),
    .out_ready(r_rdy), .full(r_full), .count(r_count), .overflow(r_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue-based FIFO, divisor and flags from the strobe rules
  // ---------------------------------------------------------------------------
  logic [7:0]  q[$];
  logic [15:0] m_brg;
  logic [7:0]  m_stage;
  bit          m_ovf, m_upd, mdl_live;
  bit          p_lo, p_hi, p_dw;
  bit          c_lo, c_hi, c_dw, do_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_brg = 16'h0; m_stage = 8'h0; m_ovf = 0; m_upd = 0;
      p_lo = 0; p_hi = 0; p_dw = 0;
      mdl_live = 1;
    end else if (mdl_live) begin
      // falling-edge commit
      c_lo   = p_lo && !brg_lo_we;
      c_hi   = p_hi && !brg_hi_we;
      c_dw   = p_dw && !data_we;
      do_pop = (q.size() != 0) && out_ready;
      m_upd  = c_hi;
      if (c_lo) m_stage = i_data;
      if (c_hi) m_brg = {i_data, m_stage};
      if (c_dw && q.size() == DEPTH && !do_pop) begin
        m_ovf = 1;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (c_dw) q.push_back(i_data);
        if (ovf_clr) m_ovf = 0;
      end
      p_lo = brg_lo_we; p_hi = brg_hi_we; p_dw = data_we;
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) check("out_data", {24'b0, out_data}, {24'b0, q[0]});
      check("count", {27'b0, count}, q.size());
      check("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
      check("count_bound", {31'b0, count <= 5'd16}, 32'd1);
      check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      check("brg_reg", {16'b0, brg_reg}, {16'b0, m_brg});
      check("brg_update", {31'b0, brg_update}, {31'b0, m_upd});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    i_data = w; data_we = 1'b1; tick();
    data_we = 1'b0; tick();
  endtask

  logic [7:0] exp_drain [16];

  initial begin
    rst = 1'b1; brg_lo_we = 0; brg_hi_we = 0; data_we = 0; ovf_clr = 0;
    out_ready = 0; i_data = 8'h00; r_we = 0; r_rdy = 0; r_zero = 0;
    tick(); tick();
    check("rst_count", {27'b0, count}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_brg", {16'b0, brg_reg}, 32'd0);
    rst = 1'b0;
    tick();

    // rising-edge build: commits as the strobe rises, once per pulse
    i_data = 8'h3C; r_we = 1'b1; tick();
    check("rise_count", {27'b0, r_count}, 32'd1);
    check("rise_data", {24'b0, r_out}, 32'h3C);
    tick(); tick();
    r_we = 1'b0; tick();
    check("rise_once", {27'b0, r_count}, 32'd1);
    r_rdy = 1'b1; tick(); r_rdy = 1'b0;
    check("rise_drained", {31'b0, r_valid}, 32'd0);

    // long strobe pushes exactly once at its fall
    i_data = 8'hA5; data_we = 1'b1; tick(); tick(); tick();
    check("hold_no_push", {27'b0, count}, 32'd0);
    data_we = 1'b0; tick();
    check("push_valid", {31'b0, out_valid}, 32'd1);
    check("push_data", {24'b0, out_data}, 32'hA5);
    check("push_count", {27'b0, count}, 32'd1);
    tick();
    check("push_once", {27'b0, count}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // divisor: lo stages, hi commits
    i_data = 8'h34; brg_lo_we = 1'b1; tick(); brg_lo_we = 1'b0; tick();
    check("brg_after_lo", {16'b0, brg_reg}, 32'h0000);
    i_data = 8'h12; brg_hi_we = 1'b1; tick(); brg_hi_we = 1'b0; tick();
    check("brg_after_hi", {16'b0, brg_reg}, 32'h1234);
    check("brg_upd_hi", {31'b0, brg_update}, 32'd1);
    tick();
    check("brg_upd_pulse", {31'b0, brg_update}, 32'd0);
    i_data = 8'h9A; brg_lo_we = 1'b1; brg_hi_we = 1'b1; tick();
    brg_lo_we = 1'b0; brg_hi_we = 1'b0; tick();
    check("brg_lo_hi_same", {16'b0, brg_reg}, 32'h9A9A);

    // fill, overflow (set beats clear), full+pop push, clear
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_count", {27'b0, count}, 32'd16);
    ovf_clr = 1'b1; push(8'hFF); ovf_clr = 1'b0;
    check("ovf_set", {31'b0, overflow}, 32'd1);
    check("ovf_count", {27'b0, count}, 32'd16);
    i_data = 8'h55; data_we = 1'b1; tick();
    data_we = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("full_pop_push", {27'b0, count}, 32'd16);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 15; i++) exp_drain[i] = 8'(i + 1);
    exp_drain[15] = 8'h55;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_order", {24'b0, out_data}, {24'b0, exp_drain[i]});
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // streaming across pointer wrap with random drain
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        data_we = 1'b1; i_data = 8'(8'h80 + i / 2);
      end else begin
        data_we = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    data_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    out_ready = 1'b0;
    check("stream_empty", {31'b0, out_valid}, 32'd0);

    // reset mid-stream drops everything, including a commit on the reset edge
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check("pre_rst_count", {27'b0, count}, 32'd5);
    i_data = 8'h77; data_we = 1'b1; tick();
    rst = 1'b1; data_we = 1'b0; tick();
    check("mid_rst_count", {27'b0, count}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_brg", {16'b0, brg_reg}, 32'd0);
    check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0; tick();
    check("post_rst_nopush", {27'b0, count}, 32'd0);

    // hi with no lo since reset uses a zero low byte
    i_data = 8'h07; brg_hi_we = 1'b1; tick(); brg_hi_we = 1'b0; tick();
    check("hi_only", {16'b0, brg_reg}, 32'h0700);
    check("hi_only_upd", {31'b0, brg_update}, 32'd1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
